// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//
// Architectural register file with rename tags. Each register holds a value,
// a busy flag and the ROB index of its youngest in-flight producer. The
// decoder renames destinations at issue and reads two source operands; the
// ROB commits results back into it. A misprediction flush drops every
// pending rename but keeps the committed values.
//
// Ports:
//   clk            system clock, state updates on the rising edge
//   rst_in         asynchronous active-low reset, clears all state
//   rdy_in         when low every register holds its state
//   roll_back      flush all rename tags / busy flags
//   de_in_en       decoder renames de_dest_in to de_rob_idx_in
//   de_dest_in     destination register being renamed
//   de_rob_idx_in  ROB entry that will produce the destination
//   de_rs1_in      source register 1 index (combinational read)
//   de_rs2_in      source register 2 index (combinational read)
//   rsN_busy_out   source waits on an in-flight producer
//   rsN_val_out    source value (meaningful when not busy)
//   rsN_dep_out    ROB index of the producer (meaningful when busy)
//   rf_in_en       ROB commits a register write this cycle
//   rf_rob_idx_in  ROB index being committed
//   rf_dest_in     committed destination register
//   rf_val_in      committed value
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int REG_NUM   = 32,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 roll_back,
    input  logic                 de_in_en,
    input  logic [4:0]           de_dest_in,
    input  logic [ROB_IDX_W-1:0] de_rob_idx_in,
    input  logic [4:0]           de_rs1_in,
    input  logic [4:0]           de_rs2_in,
    output logic                 rs1_busy_out,
    output logic [DATA_W-1:0]    rs1_val_out,
    output logic [ROB_IDX_W-1:0] rs1_dep_out,
    output logic                 rs2_busy_out,
    output logic [DATA_W-1:0]    rs2_val_out,
    output logic [ROB_IDX_W-1:0] rs2_dep_out,
    input  logic                 rf_in_en,
    input  logic [ROB_IDX_W-1:0] rf_rob_idx_in,
    input  logic [4:0]           rf_dest_in,
    input  logic [DATA_W-1:0]    rf_val_in
);

    logic [DATA_W-1:0]    val_q  [REG_NUM];
    logic [DATA_W-1:0]    val_d  [REG_NUM];
    logic                 busy_q [REG_NUM];
    logic                 busy_d [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_q  [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_d  [REG_NUM];

    logic commitHit1;
    logic commitHit2;

    // Source reads. A commit landing on the register in the same cycle is
    // forwarded: its value replaces the stored one, and it frees the source
    // only if it is the producer the tag is waiting for.
    always_comb begin
        rs1_busy_out = 1'b0;
        rs1_val_out  = '0;
        rs1_dep_out  = '0;
        commitHit1   = rf_in_en && (rf_dest_in == de_rs1_in);
        if (de_rs1_in != 5'd0) begin
            rs1_busy_out = busy_q[de_rs1_in] &&
                           !(commitHit1 && (rf_rob_idx_in == tag_q[de_rs1_in]));
            rs1_val_out  = commitHit1 ? rf_val_in : val_q[de_rs1_in];
            rs1_dep_out  = tag_q[de_rs1_in];
        end
    end

    always_comb begin
        rs2_busy_out = 1'b0;
        rs2_val_out  = '0;
        rs2_dep_out  = '0;
        commitHit2   = rf_in_en && (rf_dest_in == de_rs2_in);
        if (de_rs2_in != 5'd0) begin
            rs2_busy_out = busy_q[de_rs2_in] &&
                           !(commitHit2 && (rf_rob_idx_in == tag_q[de_rs2_in]));
            rs2_val_out  = commitHit2 ? rf_val_in : val_q[de_rs2_in];
            rs2_dep_out  = tag_q[de_rs2_in];
        end
    end

    // Next state. Commit is applied first so that a same-cycle rename to the
    // same register overrides its busy clear. A commit whose ROB index no
    // longer matches the tag belongs to an older producer and only writes
    // the value. Rollback wipes all pending renames, including one issued
    // in the flush cycle, but the commit value still lands.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (rf_in_en && (rf_dest_in != 5'd0)) begin
                val_d[rf_dest_in] = rf_val_in;
                if (tag_q[rf_dest_in] == rf_rob_idx_in) begin
                    busy_d[rf_dest_in] = 1'b0;
                end
            end
            if (roll_back) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end else if (de_in_en && (de_dest_in != 5'd0)) begin
                busy_d[de_dest_in] = 1'b1;
                tag_d[de_dest_in]  = de_rob_idx_in;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//
// Drives rename / commit / rollback sequences into reg_file. Each expected
// read result is queued when the read is set up and popped once the
// combinational outputs have settled.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic        de_in_en;
    logic [4:0]  de_dest_in;
    logic [3:0]  de_rob_idx_in;
    logic [4:0]  de_rs1_in;
    logic [4:0]  de_rs2_in;
    logic        rs1_busy_out;
    logic [31:0] rs1_val_out;
    logic [3:0]  rs1_dep_out;
    logic        rs2_busy_out;
    logic [31:0] rs2_val_out;
    logic [3:0]  rs2_dep_out;
    logic        rf_in_en;
    logic [3:0]  rf_rob_idx_in;
    logic [4:0]  rf_dest_in;
    logic [31:0] rf_val_in;

    typedef struct packed {
        logic        port;
        logic        busy;
        logic [31:0] val;
        logic [3:0]  dep;
    } readExp_t;

    readExp_t expQ[$];
    string    nameQ[$];

    int totalChecks = 0;
    int badChecks   = 0;

    reg_file #(.REG_NUM(32), .ROB_IDX_W(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .roll_back     (roll_back),
        .de_in_en      (de_in_en),
        .de_dest_in    (de_dest_in),
        .de_rob_idx_in (de_rob_idx_in),
        .de_rs1_in     (de_rs1_in),
        .de_rs2_in     (de_rs2_in),
        .rs1_busy_out  (rs1_busy_out),
        .rs1_val_out   (rs1_val_out),
        .rs1_dep_out   (rs1_dep_out),
        .rs2_busy_out  (rs2_busy_out),
        .rs2_val_out   (rs2_val_out),
        .rs2_dep_out   (rs2_dep_out),
        .rf_in_en      (rf_in_en),
        .rf_rob_idx_in (rf_rob_idx_in),
        .rf_dest_in    (rf_dest_in),
        .rf_val_in     (rf_val_in)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive the commit / rename controls for the coming edge.
    task automatic applyStimulus(input logic cEn, input logic [4:0] cDest,
                                 input logic [3:0] cIdx, input logic [31:0] cVal,
                                 input logic dEn, input logic [4:0] dDest,
                                 input logic [3:0] dIdx, input logic rb);
        rf_in_en      = cEn;
        rf_dest_in    = cDest;
        rf_rob_idx_in = cIdx;
        rf_val_in     = cVal;
        de_in_en      = dEn;
        de_dest_in    = dDest;
        de_rob_idx_in = dIdx;
        roll_back     = rb;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 5'd0, 4'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Point a read port at a register and queue what it should return.
    task automatic expectRead(input string tag, input logic port, input logic [4:0] r,
                              input logic busy, input logic [31:0] val,
                              input logic [3:0] dep);
        readExp_t e;
        if (port) de_rs2_in = r;
        else      de_rs1_in = r;
        e.port = port;
        e.busy = busy;
        e.val  = val;
        e.dep  = dep;
        expQ.push_back(e);
        nameQ.push_back(tag);
        drainReads();
    endtask

    // Let the combinational read settle, then retire queued expectations.
    task automatic drainReads();
        readExp_t e;
        string    nm;
        #1;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            if (e.port) begin
                checkOutput({nm, ".busy"}, {31'd0, rs2_busy_out}, {31'd0, e.busy});
                checkOutput({nm, ".val"},  rs2_val_out,           e.val);
                checkOutput({nm, ".dep"},  {28'd0, rs2_dep_out},  {28'd0, e.dep});
            end else begin
                checkOutput({nm, ".busy"}, {31'd0, rs1_busy_out}, {31'd0, e.busy});
                checkOutput({nm, ".val"},  rs1_val_out,           e.val);
                checkOutput({nm, ".dep"},  {28'd0, rs1_dep_out},  {28'd0, e.dep});
            end
        end
    endtask

    initial begin
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        de_rs1_in = 5'd0;
        de_rs2_in = 5'd0;
        idle();

        // Reset state
        #1;
        expectRead("resetX5", 1'b0, 5'd5, 1'b0, 32'h0, 4'd0);
        #1 rst_in = 1'b1;
        tick();

        // Commit to an idle register, bypass and stored value
        applyStimulus(1'b1, 5'd5, 4'd3, 32'h1234, 1'b0, 5'd0, 4'd0, 1'b0);
        expectRead("commitX5Bypass", 1'b0, 5'd5, 1'b0, 32'h1234, 4'd0);
        tick();
        idle();
        expectRead("commitX5Stored", 1'b0, 5'd5, 1'b0, 32'h1234, 4'd0);

        // Rename then matching commit
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd7, 4'd2, 1'b0);
        tick();
        idle();
        expectRead("renameX7", 1'b0, 5'd7, 1'b1, 32'h0, 4'd2);
        applyStimulus(1'b1, 5'd7, 4'd2, 32'hDEAD, 1'b0, 5'd0, 4'd0, 1'b0);
        expectRead("commitX7Bypass", 1'b0, 5'd7, 1'b0, 32'hDEAD, 4'd2);
        tick();
        idle();
        expectRead("commitX7Stored", 1'b0, 5'd7, 1'b0, 32'hDEAD, 4'd2);

        // Stale commit from an older producer
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd7, 4'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd7, 4'd5, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd7, 4'd2, 32'hAA, 1'b0, 5'd0, 4'd0, 1'b0);
        expectRead("staleBypass", 1'b1, 5'd7, 1'b1, 32'hAA, 4'd5);
        tick();
        idle();
        expectRead("staleStored", 1'b1, 5'd7, 1'b1, 32'hAA, 4'd5);

        // Same-cycle commit and rename to x9
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd9, 4'd4, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd9, 4'd4, 32'h55, 1'b1, 5'd9, 4'd6, 1'b0);
        tick();
        idle();
        expectRead("renameWinsX9", 1'b1, 5'd9, 1'b1, 32'h55, 4'd6);

        // Rollback with a simultaneous rename and commit
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd1, 4'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd2, 4'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd3, 4'd7, 1'b0);
        tick();
        idle();
        expectRead("preFlushX2", 1'b1, 5'd2, 1'b1, 32'h0, 4'd3);
        applyStimulus(1'b1, 5'd6, 4'd9, 32'h66, 1'b1, 5'd4, 4'd8, 1'b1);
        tick();
        idle();
        expectRead("flushX1", 1'b0, 5'd1, 1'b0, 32'h0, 4'd0);
        expectRead("flushX3", 1'b1, 5'd3, 1'b0, 32'h0, 4'd0);
        expectRead("flushX4", 1'b0, 5'd4, 1'b0, 32'h0, 4'd0);
        expectRead("flushX7", 1'b1, 5'd7, 1'b0, 32'hAA, 4'd0);
        expectRead("flushX9", 1'b0, 5'd9, 1'b0, 32'h55, 4'd0);
        expectRead("flushX5", 1'b1, 5'd5, 1'b0, 32'h1234, 4'd0);
        expectRead("flushCommitX6", 1'b0, 5'd6, 1'b0, 32'h66, 4'd0);

        // x0 ignores commits and renames
        applyStimulus(1'b1, 5'd0, 4'd3, 32'hFFFF, 1'b1, 5'd0, 4'd3, 1'b0);
        expectRead("x0Live", 1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        tick();
        idle();
        expectRead("x0Stored", 1'b1, 5'd0, 1'b0, 32'h0, 4'd0);

        // rdy_in low holds state
        rdy_in = 1'b0;
        applyStimulus(1'b1, 5'd8, 4'd0, 32'h88, 1'b1, 5'd10, 4'd5, 1'b0);
        tick();
        idle();
        rdy_in = 1'b1;
        expectRead("holdX8", 1'b0, 5'd8, 1'b0, 32'h0, 4'd0);
        expectRead("holdX10", 1'b1, 5'd10, 1'b0, 32'h0, 4'd0);

        // Asynchronous reset between clock edges
        applyStimulus(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd11, 4'd4, 1'b0);
        tick();
        idle();
        expectRead("preResetX11", 1'b1, 5'd11, 1'b1, 32'h0, 4'd4);
        #1 rst_in = 1'b0;
        expectRead("asyncResetX5", 1'b0, 5'd5, 1'b0, 32'h0, 4'd0);
        expectRead("asyncResetX11", 1'b1, 5'd11, 1'b0, 32'h0, 4'd0);
        #1 rst_in = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
